proc_issuer: RTL and testbench

PROC_ISSUER -- requirements
Module: proc_issuer

---
 rtl/proc_issuer_pkg.sv | 52 +++++
 rtl/proc_issuer_fifo.sv | 81 ++++++++
 rtl/proc_issuer.sv | 148 ++++++++++++++
 tb/tb_proc_issuer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_issuer_pkg
// Brief    : Shared types for the command issuer and its processing element
//            (addresses, ids, SIMD info, instruction word, queued command).
// Revision : 1.0 - initial release
// ============================================================================
package proc_issuer_pkg;

  localparam int ADDR_W = 16;
  localparam int ID_W   = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ID_W-1:0]   cmd_id_t;

  // Opcode 0 is reserved so that an all-zero word never looks like a command
  typedef enum logic [1:0] {
    INSTR_NOP   = 2'd0,
    INSTR_LD    = 2'd1,
    INSTR_INFO  = 2'd2,
    INSTR_STORE = 2'd3
  } instr_op_t;

  // SIMD operation and element count, packed to the width of an address
  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] count;
  } instr_info_t;

  typedef union packed {
    addr_t       addr;
    instr_info_t info;
  } instr_payload_t;

  typedef struct packed {
    instr_op_t      opcode;
    instr_payload_t payload;
  } instr_t;

  // One queued command, field order matches the queue storage layout
  typedef struct packed {
    addr_t       addr0;
    addr_t       addr1;
    addr_t       wr_addr;
    instr_info_t info;
    cmd_id_t     id;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage
`default_nettype wire

// File: rtl/proc_issuer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Brief    : Generic-width synchronous FIFO with wrap-around pointers.
//            Push is dropped when full, pop is dropped when empty; a
//            simultaneous push and pop both take effect.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL = DEPTH[PTR_W:0];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_full  = (count_q == C_FULL);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // Qualify requests, advance pointers (power-of-two depth wraps naturally)
  always_comb begin
    w_push   = i_push & ~o_full;
    w_pop    = i_pop & ~o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/proc_issuer.sv
`default_nettype none
// ============================================================================
// Module   : proc_issuer
// Brief    : Queues commands and issues each one to a processing element as
//            an enable pulse, four instruction words (LD, LD, INFO, STORE),
//            then waits for the PE to finish and acknowledges completion.
// Revision : 1.0 - initial release
// ============================================================================
module proc_issuer
  import proc_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  addr_t                       i_cmd_addr0,
  input  addr_t                       i_cmd_addr1,
  input  addr_t                       i_cmd_wr_addr,
  input  instr_info_t                 i_cmd_info,
  input  cmd_id_t                     i_cmd_id,
  output logic                        o_en,
  output logic                        o_valid,
  output instr_t                      o_instr,
  input  logic                        i_busy,
  input  logic                        i_finish,
  output logic                        o_done,
  output cmd_id_t                     o_done_id,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EN    = 3'd1,
    S_LD0   = 3'd2,
    S_LD1   = 3'd3,
    S_INFO  = 3'd4,
    S_STORE = 3'd5,
    S_WAIT  = 3'd6,
    S_ACK   = 3'd7
  } state_t;

  state_t state_q, state_d;
  cmd_t   work_q, work_d;
  cmd_t   w_cmd_in;
  cmd_t   w_head;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;

  assign w_cmd_in    = {i_cmd_addr0, i_cmd_addr1, i_cmd_wr_addr, i_cmd_info, i_cmd_id};
  assign o_cmd_ready = ~w_full;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (i_cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  // Issue sequencer: next state, head capture and per-state output words
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    w_pop     = 1'b0;
    o_en      = 1'b0;
    o_valid   = 1'b0;
    o_instr   = '0;
    o_done    = 1'b0;
    o_done_id = '0;
    case (state_q)
      S_IDLE: begin
        // The head is captured on the same edge it leaves the queue
        if (!w_empty && !i_busy) begin
          w_pop   = 1'b1;
          work_d  = w_head;
          state_d = S_EN;
        end
      end
      S_EN: begin
        o_en    = 1'b1;
        state_d = S_LD0;
      end
      S_LD0: begin
        o_valid              = 1'b1;
        o_instr.opcode       = INSTR_LD;
        o_instr.payload.addr = work_q.addr0;
        state_d              = S_LD1;
      end
      S_LD1: begin
        o_valid              = 1'b1;
        o_instr.opcode       = INSTR_LD;
        o_instr.payload.addr = work_q.addr1;
        state_d              = S_INFO;
      end
      S_INFO: begin
        o_valid              = 1'b1;
        o_instr.opcode       = INSTR_INFO;
        o_instr.payload.info = work_q.info;
        state_d              = S_STORE;
      end
      S_STORE: begin
        o_valid              = 1'b1;
        o_instr.opcode       = INSTR_STORE;
        o_instr.payload.addr = work_q.wr_addr;
        state_d              = S_WAIT;
      end
      S_WAIT: begin
        // Finish is only meaningful here; no timeout by design
        if (i_finish) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        // Valid with an all-zero word doubles as the completion acknowledge
        o_valid   = 1'b1;
        o_done    = 1'b1;
        o_done_id = work_q.id;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and working-command registers; reset abandons any in-flight command
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_issuer
// Brief    : Directed scoreboard bench for proc_issuer with a small PE model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_issuer;
  import proc_issuer_pkg::*;

  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    instr_t  instr;
    logic    done;
    cmd_id_t id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  cmd_t        cmd_in;
  logic        busy;
  logic        pe_finish;
  logic        tb_finish;
  logic        finish;
  logic        o_cmd_ready;
  logic        o_en;
  logic        o_valid;
  instr_t      o_instr;
  logic        o_done;
  cmd_id_t     o_done_id;
  logic [2:0]  o_fifo_count;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   en_cyc = -1;
  int   en_count = 0;
  int   store_cyc = -1;
  int   done_cyc = -1;
  int   done_count = 0;
  int   pe_delay = 4;
  logic pe_stall = 1'b0;

  assign finish = pe_finish | tb_finish;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  proc_issuer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_addr0  (cmd_in.addr0),
    .i_cmd_addr1  (cmd_in.addr1),
    .i_cmd_wr_addr(cmd_in.wr_addr),
    .i_cmd_info   (cmd_in.info),
    .i_cmd_id     (cmd_in.id),
    .o_en         (o_en),
    .o_valid      (o_valid),
    .o_instr      (o_instr),
    .i_busy       (busy),
    .i_finish     (finish),
    .o_done       (o_done),
    .o_done_id    (o_done_id),
    .o_fifo_count (o_fifo_count)
  );

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic cmd_t mk(input addr_t a0, input addr_t a1, input addr_t wr,
                              input logic [3:0] op, input logic [11:0] cnt, input cmd_id_t id);
    cmd_t c;
    c.addr0      = a0;
    c.addr1      = a1;
    c.wr_addr    = wr;
    c.info.op    = op;
    c.info.count = cnt;
    c.id         = id;
    return c;
  endfunction

  // Expected word stream for one command: LD a0, LD a1, INFO, STORE wr, ACK
  function automatic void sb_push(input cmd_t c);
    exp_t e;
    e = '0; e.instr.opcode = INSTR_LD;    e.instr.payload.addr = c.addr0;   sb.push_back(e);
    e = '0; e.instr.opcode = INSTR_LD;    e.instr.payload.addr = c.addr1;   sb.push_back(e);
    e = '0; e.instr.opcode = INSTR_INFO;  e.instr.payload.info = c.info;    sb.push_back(e);
    e = '0; e.instr.opcode = INSTR_STORE; e.instr.payload.addr = c.wr_addr; sb.push_back(e);
    e = '0; e.done = 1'b1; e.id = c.id; sb.push_back(e);
  endfunction

  // Drive a command now (at a falling edge with ready high); accepted next edge
  task automatic push_now(input cmd_t c, output int t);
    cmd_in    = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    sb_push(c);
    #1;
    t         = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic push(input cmd_t c, output int t);
    int g = 0;
    @(negedge clk);
    while (!o_cmd_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!o_cmd_ready) chk("push_ready_timeout", {63'd0, o_cmd_ready}, 64'd1);
    push_now(c, t);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int g = 0;
    while (done_count < target && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk(name, 64'(done_count >= target), 64'd1);
  endtask

  // Output monitor: pops the scoreboard on every valid word
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (o_valid) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_word: got instr=0x%0h done=%0b id=%0d expected no output (cycle %0d)",
                     o_instr, o_done, o_done_id, cyc);
          end else begin
            e = sb.pop_front();
            chk("out_word", {41'd0, o_instr, o_done, o_done_id}, {41'd0, e});
          end
          if (o_instr.opcode == INSTR_STORE) store_cyc = cyc;
          if (o_done) begin
            done_cyc = cyc;
            done_count++;
          end
        end else begin
          chk("idle_outputs_zero", {41'd0, o_instr, o_done, o_done_id}, 64'd0);
        end
        if (o_en) begin
          en_cyc = cyc;
          en_count++;
        end
        if (!o_cmd_ready) chk("count_when_not_ready", 64'(o_fifo_count), 64'(FIFO_DEPTH));
      end
    end
  endtask

  // PE model: raise finish pe_delay cycles after STORE (later if stalled)
  task automatic pe_loop();
    forever begin
      @(negedge clk);
      if (rstn && o_valid && o_instr.opcode == INSTR_STORE) begin
        int g = 0;
        while (pe_stall && g < 2000) begin
          @(negedge clk);
          g++;
        end
        repeat (pe_delay) @(negedge clk);
        pe_finish = 1'b1;
        @(negedge clk);
        pe_finish = 1'b0;
      end
    end
  endtask

  task automatic run_tests();
    int t;
    int base;
    int g;
    cmd_t c;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_en", 64'(o_en), 64'd0);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_instr", 64'(o_instr), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_done_id", 64'(o_done_id), 64'd0);
    chk("reset_count", 64'(o_fifo_count), 64'd0);
    chk("reset_ready", 64'(o_cmd_ready), 64'd1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single command latency and word contents
    push(mk(16'd16, 16'd32, 16'd48, 4'd0, 12'd5, 4'd3), t);
    wait_done(1, 100, "t1_done_seen");
    chk("t1_en_cycle", 64'(en_cyc), 64'(t + 1));
    chk("t1_store_cycle", 64'(store_cyc), 64'(t + 5));
    chk("t1_done_cycle", 64'(done_cyc), 64'(t + 10));
    chk("t1_en_pulses", 64'(en_count), 64'd1);

    // Overfill while the PE stalls in WAIT; nothing lost, in-order completion
    pe_stall = 1'b1;
    base = done_count;
    fork
      begin
        for (int i = 0; i < FIFO_DEPTH + 2; i++)
          push(mk(16'h100 + 16'(i), 16'h200 + 16'(i), 16'h300 + 16'(i), 4'(i), 12'(i + 1), 4'(i)), t);
      end
      begin
        g = 0;
        while (o_cmd_ready && g < 60) begin
          @(negedge clk);
          g++;
        end
        chk("t2_ready_fell", 64'(o_cmd_ready), 64'd0);
        chk("t2_count_at_full", 64'(o_fifo_count), 64'(FIFO_DEPTH));
        repeat (5) @(negedge clk);
        pe_stall = 1'b0;
      end
    join
    wait_done(base + FIFO_DEPTH + 2, 500, "t2_all_done");
    chk("t2_sb_drained", 64'(sb.size()), 64'd0);

    // Busy held in IDLE blocks the start
    @(negedge clk);
    busy = 1'b1;
    base = en_count;
    push(mk(16'h0A0, 16'h0B0, 16'h0C0, 4'd2, 12'd7, 4'd6), t);
    repeat (10) @(negedge clk);
    chk("t3_no_en_while_busy", 64'(en_count - base), 64'd0);
    busy = 1'b0;
    @(negedge clk);
    chk("t3_en_after_busy", 64'(o_en), 64'd1);
    wait_done(done_count + 1, 100, "t3_done");

    // Simultaneous push and pop at count 2
    @(negedge clk);
    busy = 1'b1;
    push(mk(16'h1111, 16'h1112, 16'h1113, 4'd1, 12'd1, 4'd7), t);
    push(mk(16'h2221, 16'h2222, 16'h2223, 4'd1, 12'd2, 4'd8), t);
    @(negedge clk);
    chk("t4_count_before", 64'(o_fifo_count), 64'd2);
    base = done_count;
    busy = 1'b0;
    push_now(mk(16'h3331, 16'h3332, 16'h3333, 4'd1, 12'd3, 4'd9), t);
    @(negedge clk);
    chk("t4_count_same", 64'(o_fifo_count), 64'd2);
    chk("t4_en", 64'(o_en), 64'd1);
    wait_done(base + 3, 200, "t4_done");

    // Finish during LD1 is ignored; completion follows the real finish
    pe_delay = 3;
    c = mk(16'h4441, 16'h4442, 16'h4443, 4'd5, 12'd9, 4'd10);
    base = done_count;
    push(c, t);
    g = 0;
    while (!(o_valid && o_instr.opcode == INSTR_LD && o_instr.payload.addr == c.addr1) && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("t5_ld1_seen", 64'(g < 40), 64'd1);
    tb_finish = 1'b1;
    @(negedge clk);
    tb_finish = 1'b0;
    wait_done(base + 1, 100, "t5_done");
    chk("t5_done_cycle", 64'(done_cyc), 64'(store_cyc + 4));

    // Reset during INFO with three commands still queued
    pe_delay = 4;
    @(negedge clk);
    busy = 1'b1;
    for (int i = 0; i < 4; i++)
      push(mk(16'h500 + 16'(i), 16'h600 + 16'(i), 16'h700 + 16'(i), 4'd3, 12'd4, 4'(11 + i)), t);
    @(negedge clk);
    busy = 1'b0;
    g = 0;
    while (!(o_valid && o_instr.opcode == INSTR_INFO) && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("t6_info_seen", 64'(g < 40), 64'd1);
    #1;
    chk("t6_queued_before", 64'(o_fifo_count), 64'd3);
    rstn = 1'b0;
    sb.delete();
    base = done_count;
    #1;
    chk("t6_async_valid", 64'(o_valid), 64'd0);
    chk("t6_async_count", 64'(o_fifo_count), 64'd0);
    @(negedge clk);
    chk("t6_valid", 64'(o_valid), 64'd0);
    chk("t6_instr", 64'(o_instr), 64'd0);
    chk("t6_count", 64'(o_fifo_count), 64'd0);
    chk("t6_ready", 64'(o_cmd_ready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_no_done", 64'(done_count - base), 64'd0);
    chk("t6_count_after", 64'(o_fifo_count), 64'd0);
    chk("t6_en_idle", 64'(o_en), 64'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_in    = '0;
    busy      = 1'b0;
    pe_finish = 1'b0;
    tb_finish = 1'b0;
    fork
      monitor_loop();
      pe_loop();
      run_tests();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
